// File: rtl/fetch_ctrl.sv
// Single-slot instruction fetch controller: issues one request at a time, tracks the
// occupied slot for decode and drops responses orphaned by redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        data_ok_o,
    input  logic        accept_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] perfcnt_discard
);

    typedef enum logic [0:0] {StReq, StWait} state_e;

    localparam logic [4:0] ExcAdEL = 5'h04;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_discard_cnt;
    logic        r_data_seen;

    logic w_misaligned;
    logic w_discard_dec;
    logic w_discard_inc;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign inst_addr    = r_pc;
    assign inst_req     = (r_state == StReq) && !w_misaligned && (r_discard_cnt != 2'd3) &&
                          !redirect_i && resetn;
    assign data_ok_o    = inst_data_ok && (r_discard_cnt == 2'd0);

    // A redirect orphans the in-flight response only if it has not arrived yet,
    // including this cycle, and the slot really issued a request.
    assign w_discard_dec = inst_data_ok && (r_discard_cnt != 2'd0);
    assign w_discard_inc = redirect_i && (r_state == StWait) && !r_data_seen && !exc_o &&
                           !data_ok_o;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= StReq;
            r_pc            <= RESET_PC;
            valid_o         <= 1'b0;
            pc_o            <= 32'h0;
            exc_o           <= 1'b0;
            exccode_o       <= 5'h0;
            r_discard_cnt   <= 2'd0;
            r_data_seen     <= 1'b0;
            perfcnt_discard <= 32'h0;
        end else begin
            r_discard_cnt <= r_discard_cnt + {1'b0, w_discard_inc} - {1'b0, w_discard_dec};
            if (w_discard_dec) begin
                perfcnt_discard <= perfcnt_discard + 32'd1;
            end

            if (redirect_i) begin
                r_pc    <= redirect_pc_i;
                valid_o <= 1'b0;
                exc_o   <= 1'b0;
                r_state <= StReq;
            end else begin
                unique case (r_state)
                    StReq: begin
                        if (w_misaligned) begin
                            r_state   <= StWait;
                            valid_o   <= 1'b1;
                            pc_o      <= r_pc;
                            exc_o     <= 1'b1;
                            exccode_o <= ExcAdEL;
                        end else if (inst_req && inst_addr_ok) begin
                            r_state     <= StWait;
                            valid_o     <= 1'b1;
                            pc_o        <= r_pc;
                            exc_o       <= 1'b0;
                            exccode_o   <= 5'h0;
                            r_data_seen <= 1'b0;
                        end
                    end
                    StWait: begin
                        if (data_ok_o) begin
                            r_data_seen <= 1'b1;
                        end
                        if (accept_i) begin
                            r_state <= StReq;
                            valid_o <= 1'b0;
                            exc_o   <= 1'b0;
                            r_pc    <= r_pc + 32'd4;
                        end
                    end
                    default: r_state <= StReq;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main flow plus hand-written
// sequences for discard saturation, coincident redirect/response and reset mid-slot.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_ok_o;
    logic        accept_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        exc_o;
    logic [4:0]  exccode_o;
    logic [31:0] perfcnt_discard;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'hBFC00000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .data_ok_o       (data_ok_o),
        .accept_i        (accept_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .valid_o         (valid_o),
        .pc_o            (pc_o),
        .exc_o           (exc_o),
        .exccode_o       (exccode_o),
        .perfcnt_discard (perfcnt_discard)
    );

    typedef struct {
        logic        aok, dok, acc, rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        doko, valid;
        logic [31:0] pco;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] perf;
    } vec_t;

    vec_t tbl[16];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic aok, input logic dok, input logic acc, input logic rd,
                          input logic [31:0] rpc);
        inst_addr_ok  = aok;
        inst_data_ok  = dok;
        accept_i      = acc;
        redirect_i    = rd;
        redirect_pc_i = rpc;
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_in(0, 0, 0, 0, 32'h0);
        step();
        step();
        resetn = 1'b1;
    endtask

    function automatic vec_t mk(input logic aok, input logic dok, input logic acc,
                                input logic rd, input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic doko, input logic valid,
                                input logic [31:0] pco, input logic exc, input logic [4:0] code,
                                input logic [31:0] perf);
        vec_t v;
        v.aok = aok; v.dok = dok; v.acc = acc; v.rd = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.doko = doko; v.valid = valid;
        v.pco = pco; v.exc = exc; v.code = code; v.perf = perf;
        return v;
    endfunction

    initial begin
        //            aok dok acc rd  rpc           req addr          dok val pc_o          exc code perf
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,         1, 32'hBFC00000, 0, 0, 32'h0,        0, 5'h0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h0,         0, 32'hBFC00000, 1, 1, 32'hBFC00000, 0, 5'h0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 32'h0,         0, 32'hBFC00000, 0, 1, 32'hBFC00000, 0, 5'h0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 32'h0,         1, 32'hBFC00004, 0, 0, 32'hBFC00000, 0, 5'h0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 32'h80001000,  0, 32'hBFC00004, 0, 1, 32'hBFC00004, 0, 5'h0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h80001000, 0, 0, 32'hBFC00004, 0, 5'h0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h80001000, 0, 0, 32'hBFC00004, 0, 5'h0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h80001000, 1, 1, 32'h80001000, 0, 5'h0, 1);
        tbl[8]  = mk(0, 0, 1, 1, 32'h80002000,  0, 32'h80001000, 0, 1, 32'h80001000, 0, 5'h0, 1);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,         1, 32'h80002000, 0, 0, 32'h80001000, 0, 5'h0, 1);
        tbl[10] = mk(0, 1, 0, 0, 32'h0,         1, 32'h80002000, 1, 0, 32'h80001000, 0, 5'h0, 1);
        tbl[11] = mk(1, 0, 0, 1, 32'h80000002,  0, 32'h80002000, 0, 0, 32'h80001000, 0, 5'h0, 1);
        tbl[12] = mk(1, 0, 0, 0, 32'h0,         0, 32'h80000002, 0, 0, 32'h80001000, 0, 5'h0, 1);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,         0, 32'h80000002, 0, 1, 32'h80000002, 1, 5'h4, 1);
        tbl[14] = mk(0, 0, 1, 0, 32'h0,         0, 32'h80000002, 0, 1, 32'h80000002, 1, 5'h4, 1);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,         0, 32'h80000006, 0, 0, 32'h80000002, 0, 5'h4, 1);

        // Reset state, observed while resetn is still low
        resetn = 1'b0;
        set_in(1, 0, 0, 0, 32'h0);
        step();
        step();
        #2;
        chk("reset_req",   inst_req, 0);
        chk("reset_state", {inst_addr, valid_o, pc_o, exc_o, exccode_o, perfcnt_discard},
            {32'hBFC00000, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0});
        inst_addr_ok = 1'b0;
        step();
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].aok, tbl[i].dok, tbl[i].acc, tbl[i].rd, tbl[i].rpc);
            #2;
            chk($sformatf("vec%0d", i),
                {inst_req, inst_addr, data_ok_o, valid_o, pc_o, exc_o, exccode_o, perfcnt_discard},
                {tbl[i].req, tbl[i].addr, tbl[i].doko, tbl[i].valid, tbl[i].pco, tbl[i].exc,
                 tbl[i].code, tbl[i].perf});
            step();
        end

        // Three orphaned requests saturate the discard counter
        do_reset();
        set_in(1, 0, 0, 0, 32'h0);        step();
        set_in(0, 0, 0, 1, 32'h80000000); step();
        set_in(1, 0, 0, 0, 32'h0);        step();
        set_in(0, 0, 0, 1, 32'h80000010); step();
        set_in(1, 0, 0, 0, 32'h0);        step();
        set_in(0, 0, 0, 1, 32'h80000020); step();
        set_in(1, 0, 0, 0, 32'h0);
        #2;
        chk("sat_block_req", inst_req, 0);
        step();
        set_in(0, 1, 0, 0, 32'h0);
        #2;
        chk("sat_masked_dok", data_ok_o, 0);
        chk("sat_still_blocked", inst_req, 0);
        step();
        set_in(1, 0, 0, 0, 32'h0);
        #2;
        chk("sat_drain_req", {inst_req, inst_addr}, {1'b1, 32'h80000020});
        chk("sat_perf", perfcnt_discard, 1);
        step();

        // Redirect coinciding with a forwarded response adds no discard
        do_reset();
        set_in(1, 0, 0, 0, 32'h0); step();
        set_in(0, 1, 0, 1, 32'h80000100);
        #2;
        chk("redir_fwd_dok", data_ok_o, 1);
        step();
        set_in(0, 1, 0, 0, 32'h0);
        #2;
        chk("redir_fwd_no_discard", {data_ok_o, inst_req, inst_addr}, {1'b1, 1'b1, 32'h80000100});
        step();

        // Redirect plus a draining response: counter stays at 1
        set_in(1, 0, 0, 0, 32'h0);        step();
        set_in(0, 0, 0, 1, 32'h80000200); step();
        set_in(1, 0, 0, 0, 32'h0);        step();
        set_in(0, 1, 0, 1, 32'h80000300);
        #2;
        chk("net_zero_masked", data_ok_o, 0);
        step();
        set_in(0, 1, 0, 0, 32'h0);
        #2;
        chk("net_zero_still_one", data_ok_o, 0);
        step();
        set_in(0, 1, 0, 0, 32'h0);
        #2;
        chk("net_zero_drained", {data_ok_o, perfcnt_discard}, {1'b1, 32'd2});
        step();

        // Reset mid-slot abandons it and disables filtering afterwards
        set_in(1, 0, 0, 0, 32'h0); step();
        resetn = 1'b0;
        #2;
        chk("rst_mid_req", inst_req, 0);
        step();
        #2;
        chk("rst_mid_state", {valid_o, inst_addr, perfcnt_discard}, {1'b0, 32'hBFC00000, 32'h0});
        resetn = 1'b1;
        step();
        set_in(0, 1, 0, 0, 32'h0);
        #2;
        chk("rst_unfiltered", data_ok_o, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000: PC of the first fetch after reset.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 inst_req  output  1  instruction memory request valid.
REQ-005 inst_addr  output  32  request address; always equals the internal fetch PC.
REQ-006 inst_addr_ok  input  1  request accepted when inst_req && inst_addr_ok.
REQ-007 inst_data_ok  input  1  raw response strobe from memory; responses return in request order.
REQ-008 data_ok_o  output  1  filtered response strobe to decode; stale responses removed.
REQ-009 accept_i  input  1  decode handshake complete (decode done && ready); slot retires.
REQ-010 redirect_i  input  1  branch/exception redirect request.
REQ-011 redirect_pc_i  input  32  redirect target.
REQ-012 valid_o  output  1  fetch slot occupied; presented to decode.
REQ-013 pc_o  output  32  PC of the occupied slot.
REQ-014 exc_o  output  1  slot carries a fetch exception.
REQ-015 exccode_o  output  5  exception code; 5'h04 (AdEL) when exc_o is 1.
REQ-016 perfcnt_discard  output  32  count of discarded responses.

Function
REQ-017 The FSM SHALL have two states: REQ (slot empty, may issue) and WAIT (slot occupied).
REQ-018 In REQ, inst_req SHALL equal pc[1:0]==0 && discard_cnt!=3 && !redirect_i && resetn.
REQ-019 REQ -> WAIT on inst_req && inst_addr_ok: valid_o<=1, pc_o<=pc, exc_o<=0, data_seen<=0.
REQ-020 REQ -> WAIT when pc[1:0]!=0, with no request issued: valid_o<=1, pc_o<=pc, exc_o<=1, exccode_o<=5'h04.
REQ-021 discard_cnt is a 2-bit counter; data_ok_o SHALL be inst_data_ok && discard_cnt==0 (combinational, zero latency).
REQ-022 inst_data_ok with discard_cnt>0 SHALL decrement discard_cnt and increment perfcnt_discard by 1, wrapping at 2^32.
REQ-023 data_ok_o in WAIT SHALL set data_seen<=1; a second data_ok_o in the same slot is illegal and is not checked.
REQ-024 WAIT -> REQ on accept_i: valid_o<=0, exc_o<=0, pc<=pc+4 (mod 2^32).
REQ-025 redirect_i SHALL take priority over accept_i and over issuing; it sets pc<=redirect_pc_i, valid_o<=0, exc_o<=0, and state<=REQ.
REQ-026 On redirect in WAIT with !data_seen && !exc_o, the outstanding response SHALL be discarded: discard_cnt+1.
REQ-027 On redirect in the same cycle as an inst_data_ok that would be forwarded, data_ok_o SHALL still pulse and no discard is added.
REQ-028 If redirect and a decrementing inst_data_ok coincide, the net discard_cnt change SHALL be the sum of both effects (+1-1=0).
REQ-029 While discard_cnt==3, no request SHALL be issued until a response drains the counter.
REQ-030 accept_i in REQ state SHALL be ignored.
REQ-031 inst_addr SHALL be stable while inst_req is high and inst_addr_ok is low.

Reset
REQ-032 While resetn==0: pc<=RESET_PC, state<=REQ, valid_o<=0, pc_o<=0, exc_o<=0, exccode_o<=0, discard_cnt<=0, data_seen<=0, perfcnt_discard<=0; inst_req held 0.
REQ-033 Reset asserted mid-WAIT SHALL abandon the slot; responses arriving after reset are not filtered; memory is reset together with this block.

Verification
REQ-034 Reset release, inst_addr_ok=1, data_ok one cycle later, accept_i next cycle -> inst_addr=BFC00000, pc_o=BFC00000, data_ok_o=1, next inst_addr=BFC00004.
REQ-035 Redirect to 80001000 in WAIT before data_ok -> valid_o=0, discard_cnt=1; next inst_data_ok masked (data_ok_o=0), perfcnt_discard=1; new request addresses 80001000.
REQ-036 Three back-to-back redirects each after an accepted request, no responses -> discard_cnt=3, inst_req=0; one inst_data_ok -> inst_req returns to 1.
REQ-037 Redirect to 80000002 -> no inst_req, valid_o=1, exc_o=1, exccode_o=04, pc_o=80000002; accept_i -> exc_o=0.
REQ-038 redirect_i and accept_i in the same cycle -> next pc=redirect_pc_i, not pc+4; if data_seen=1, no discard is added.
